// File: rtl/mem_store_sink.sv
// mem_store_sink: data-store responder for the pipelined ARM core.
// Word-addressed RAM with combinational read, FWFT log of accepted stores,
// and a status FSM that ends the run on a magic-address store or a cycle budget.
// Optional build macro STORE_SINK_BOUNDS_CHECK_EN: misaligned or out-of-range
// stores skip the RAM write and set the sticky bounds_err flag.
module mem_store_sink #(
    parameter int unsigned ADDR_BITS      = 6,
    parameter int unsigned LOG_DEPTH      = 8,
    parameter logic [31:0] MAGIC_ADDR     = 32'h64,
    parameter logic [31:0] PASS_VALUE     = 32'd7,
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         MemWrite,
    input  logic [31:0]                  DataAdr,
    input  logic [31:0]                  WriteData,
    output logic [31:0]                  ReadData,
    input  logic                         log_pop,
    output logic                         log_valid,
    output logic [31:0]                  log_adr,
    output logic [31:0]                  log_data,
    output logic [$clog2(LOG_DEPTH):0]   log_count,
    output logic                         log_overflow,
    output logic [1:0]                   status,
    output logic                         done,
    output logic [31:0]                  cycle_count,
    output logic                         bounds_err
);

    localparam int unsigned PTR_W     = $clog2(LOG_DEPTH);
    localparam int unsigned CNT_W     = PTR_W + 1;
    localparam int unsigned RAM_WORDS = 1 << ADDR_BITS;

    typedef enum logic [1:0] {
        ST_RUN     = 2'b00,
        ST_PASS    = 2'b01,
        ST_FAIL    = 2'b10,
        ST_TIMEOUT = 2'b11
    } stateT;

    typedef struct packed {
        logic [31:0] adr;
        logic [31:0] data;
    } logEntryT;

    stateT              state;
    stateT              stateNext;
    logic [31:0]        ram [RAM_WORDS];
    logEntryT           entries [LOG_DEPTH];
    logic [PTR_W-1:0]   wrPtr;
    logic [PTR_W-1:0]   rdPtr;
    logic [CNT_W-1:0]   cnt;
    logic               storeAcc;
    logic               isMagic;
    logic               logFull;
    logic               doPush;
    logic               doPop;
    logic               adrBad;
    logic               ramWe;

    assign storeAcc = MemWrite && (state == ST_RUN);
    assign isMagic  = storeAcc && (DataAdr == MAGIC_ADDR);
    assign logFull  = (cnt == CNT_W'(LOG_DEPTH));
    assign doPop    = log_pop && (cnt != '0);
    assign doPush   = storeAcc && (!logFull || doPop);

`ifdef STORE_SINK_BOUNDS_CHECK_EN
    assign adrBad = (DataAdr[1:0] != 2'b00) || (DataAdr >= 32'(4 * RAM_WORDS));

    // Sticky flag for any accepted store with a bad address
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bounds_err <= 1'b0;
        end else if (storeAcc && adrBad) begin
            bounds_err <= 1'b1;
        end
    end
`else
    assign adrBad     = 1'b0;
    assign bounds_err = 1'b0;
`endif

    assign ramWe = storeAcc && !adrBad;

    // Data RAM: write on accepted store, contents survive reset
    always_ff @(posedge clk) begin
        if (ramWe) begin
            ram[DataAdr[ADDR_BITS+1:2]] <= WriteData;
        end
    end

    // Combinational read; a same-cycle store shows up only after the edge
    assign ReadData = ram[DataAdr[ADDR_BITS+1:2]];

    // Store-log FIFO: pointers, occupancy, storage and sticky overflow
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrPtr        <= '0;
            rdPtr        <= '0;
            cnt          <= '0;
            log_overflow <= 1'b0;
            for (int unsigned i = 0; i < LOG_DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else begin
            if (doPush) begin
                entries[wrPtr] <= '{adr: DataAdr, data: WriteData};
                wrPtr          <= wrPtr + PTR_W'(1);
            end
            if (doPop) begin
                rdPtr <= rdPtr + PTR_W'(1);
            end
            if (doPush && !doPop) begin
                cnt <= cnt + CNT_W'(1);
            end else if (!doPush && doPop) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (storeAcc && logFull && !doPop) begin
                log_overflow <= 1'b1;
            end
        end
    end

    assign log_valid = (cnt != '0);
    assign log_count = cnt;
    assign log_adr   = entries[rdPtr].adr;
    assign log_data  = entries[rdPtr].data;

    // Status FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_RUN;
        end else begin
            state <= stateNext;
        end
    end

    // Next state: magic store wins over the timeout on the same cycle
    always_comb begin
        stateNext = state;
        case (state)
            ST_RUN: begin
                if (isMagic) begin
                    stateNext = (WriteData == PASS_VALUE) ? ST_PASS : ST_FAIL;
                end else if (cycle_count == 32'(TIMEOUT_CYCLES - 1)) begin
                    stateNext = ST_TIMEOUT;
                end
            end
            default: stateNext = state;
        endcase
    end

    // Cycles spent in RUN; frozen once the run has ended
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_count <= '0;
        end else if ((state == ST_RUN) && (stateNext == ST_RUN)) begin
            cycle_count <= cycle_count + 32'd1;
        end
    end

    assign status = state;
    assign done   = (state != ST_RUN);

endmodule

// File: tb/tb_mem_store_sink.sv
// Directed testbench for mem_store_sink (default parameters).
module tb_mem_store_sink;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemWrite;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        log_pop;
    logic        log_valid;
    logic [31:0] log_adr;
    logic [31:0] log_data;
    logic [3:0]  log_count;
    logic        log_overflow;
    logic [1:0]  status;
    logic        done;
    logic [31:0] cycle_count;
    logic        bounds_err;

    int          total = 0;
    int          bad   = 0;
    int          edges = 0;
    logic [31:0] ccHold;

    always #5 clk = ~clk;

    mem_store_sink dut (
        .clk          (clk),
        .reset        (reset),
        .MemWrite     (MemWrite),
        .DataAdr      (DataAdr),
        .WriteData    (WriteData),
        .ReadData     (ReadData),
        .log_pop      (log_pop),
        .log_valid    (log_valid),
        .log_adr      (log_adr),
        .log_data     (log_data),
        .log_count    (log_count),
        .log_overflow (log_overflow),
        .status       (status),
        .done         (done),
        .cycle_count  (cycle_count),
        .bounds_err   (bounds_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        edges++;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        MemWrite  = 1'b1;
        DataAdr   = a;
        WriteData = d;
        step();
        MemWrite  = 1'b0;
    endtask

    task automatic pop();
        log_pop = 1'b1;
        step();
        log_pop = 1'b0;
    endtask

    initial begin
        reset = 1'b1; MemWrite = 1'b0; log_pop = 1'b0;
        DataAdr = '0; WriteData = '0;

        // reset state
        #12;
        chk("rst_status", 32'(status), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_cycles", cycle_count, 32'd0);
        chk("rst_valid", 32'(log_valid), 32'd0);
        chk("rst_count", 32'(log_count), 32'd0);
        chk("rst_ovf", 32'(log_overflow), 32'd0);
        chk("rst_bounds", 32'(bounds_err), 32'd0);
        chk("rst_adr", log_adr, 32'd0);
        chk("rst_data", log_data, 32'd0);
        @(posedge clk); #1; reset = 1'b0; edges = 0;

        // two stores, read back, drain log in order
        store(32'h10, 32'hAA);
        store(32'h14, 32'hBB);
        DataAdr = 32'h10; #1;
        chk("rd_10", ReadData, 32'hAA);
        chk("cnt_2", 32'(log_count), 32'd2);
        chk("valid_2", 32'(log_valid), 32'd1);
        chk("head0_adr", log_adr, 32'h10);
        chk("head0_data", log_data, 32'hAA);
        pop();
        chk("head1_adr", log_adr, 32'h14);
        chk("head1_data", log_data, 32'hBB);
        chk("cnt_1", 32'(log_count), 32'd1);
        pop();
        chk("cnt_0", 32'(log_count), 32'd0);
        chk("valid_0", 32'(log_valid), 32'd0);
        pop();
        chk("pop_empty", 32'(log_count), 32'd0);

        // read-old-data on a same-cycle store
        MemWrite = 1'b1; DataAdr = 32'h10; WriteData = 32'h11; #1;
        chk("rd_old", ReadData, 32'hAA);
        step(); MemWrite = 1'b0;
        chk("rd_new", ReadData, 32'h11);
        pop();
        chk("cycles_a", cycle_count, 32'(edges));

        // fill the log, simultaneous push/pop while full, then overflow
        for (int i = 0; i < 8; i++) store(32'h20 + 32'(4 * i), 32'(i + 1));
        chk("full_cnt", 32'(log_count), 32'd8);
        chk("full_ovf", 32'(log_overflow), 32'd0);
        MemWrite = 1'b1; DataAdr = 32'h40; WriteData = 32'h99; log_pop = 1'b1;
        step(); MemWrite = 1'b0; log_pop = 1'b0;
        chk("pp_cnt", 32'(log_count), 32'd8);
        chk("pp_ovf", 32'(log_overflow), 32'd0);
        chk("pp_head", log_adr, 32'h24);
        store(32'h44, 32'h55);
        chk("ovf_cnt", 32'(log_count), 32'd8);
        chk("ovf_set", 32'(log_overflow), 32'd1);
        for (int i = 1; i < 8; i++) begin
            chk("drain_adr", log_adr, 32'h20 + 32'(4 * i));
            chk("drain_data", log_data, 32'(i + 1));
            pop();
        end
        chk("tail_adr", log_adr, 32'h40);
        chk("tail_data", log_data, 32'h99);
        pop();
        chk("drained", 32'(log_valid), 32'd0);
        chk("ovf_sticky", 32'(log_overflow), 32'd1);

        // misaligned / out-of-range store
        store(32'h0, 32'h1234);
        store(32'h102, 32'hDEAD);
        DataAdr = 32'h0; #1;
`ifdef STORE_SINK_BOUNDS_CHECK_EN
        chk("alias_ram", ReadData, 32'h1234);
        chk("alias_berr", 32'(bounds_err), 32'd1);
`else
        chk("alias_ram", ReadData, 32'hDEAD);
        chk("alias_berr", 32'(bounds_err), 32'd0);
`endif
        pop();
        chk("alias_log_adr", log_adr, 32'h102);
        chk("alias_log_data", log_data, 32'hDEAD);
        pop();
        chk("cycles_b", cycle_count, 32'(edges));

        // PASS, then terminal behaviour
        ccHold = 32'(edges);
        store(32'h64, 32'd7);
        chk("pass_status", 32'(status), 32'd1);
        chk("pass_done", 32'(done), 32'd1);
        chk("pass_cycles", cycle_count, ccHold);
        chk("pass_log_adr", log_adr, 32'h64);
        chk("pass_log_data", log_data, 32'd7);
        DataAdr = 32'h64; #1;
        chk("pass_ram", ReadData, 32'd7);
        store(32'h20, 32'h77);
        DataAdr = 32'h20; #1;
        chk("post_ram", ReadData, 32'd1);
        chk("post_cnt", 32'(log_count), 32'd1);
        chk("post_cycles", cycle_count, ccHold);
        chk("post_status", 32'(status), 32'd1);
        pop();
        chk("post_pop", 32'(log_count), 32'd0);

        // reset mid-run with three log entries takes effect immediately
        reset = 1'b1; step(); reset = 1'b0; edges = 0;
        store(32'h30, 32'd1);
        store(32'h34, 32'd2);
        store(32'h38, 32'd3);
        chk("mid_cnt", 32'(log_count), 32'd3);
        chk("mid_cycles", cycle_count, 32'd3);
        #2; reset = 1'b1; #1;
        chk("mid_valid", 32'(log_valid), 32'd0);
        chk("mid_status", 32'(status), 32'd0);
        chk("mid_cycles0", cycle_count, 32'd0);
        chk("mid_count0", 32'(log_count), 32'd0);
        step(); reset = 1'b0; edges = 0;

        // FAIL value at the magic address
        store(32'h64, 32'd3);
        chk("fail_status", 32'(status), 32'd2);
        chk("fail_done", 32'(done), 32'd1);

        // magic store on the timeout cycle wins
        reset = 1'b1; step(); reset = 1'b0; edges = 0;
        repeat (999) step();
        chk("edge_cycles", cycle_count, 32'd999);
        chk("edge_run", 32'(status), 32'd0);
        store(32'h64, 32'd7);
        chk("edge_pass", 32'(status), 32'd1);

        // idle run reaches TIMEOUT
        reset = 1'b1; step(); reset = 1'b0; edges = 0;
        for (int i = 0; i < 1100 && !done; i++) step();
        chk("to_edges", 32'(edges), 32'd1000);
        chk("to_status", 32'(status), 32'd3);
        chk("to_cycles", cycle_count, 32'd999);
        step();
        chk("to_frozen", cycle_count, 32'd999);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
